// File: rtl/pagerank_pe_if.sv
// NoC-facing bundle of a PageRank processing element: remote fetch, query/reply
// service and the inter-PE iteration barrier.
interface pagerank_pe_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned PW    = 6
);
    logic                req_valid;
    logic [PW-1:0]       req_page;
    logic                req_ready;
    logic                rsp_valid;
    logic [WIDTH+PW-1:0] rsp_data;
    logic                qry_valid;
    logic [PW-1:0]       qry_page;
    logic                rep_valid;
    logic [WIDTH-1:0]    rep_data;
    logic                sync_done;
    logic                sync_go;

    modport master (
        output req_valid, req_page, rep_valid, rep_data, sync_done,
        input  req_ready, rsp_valid, rsp_data, qry_valid, qry_page, sync_go
    );
    modport slave (
        input  req_valid, req_page, rep_valid, rep_data, sync_done,
        output req_ready, rsp_valid, rsp_data, qry_valid, qry_page, sync_go
    );
endinterface

// File: rtl/pagerank_pe.sv
// PageRank processing element: owns N pages, pulls remote contributions over the
// NoC, serves contribution queries and double-buffers values across iterations.
module pagerank_pe #(
    parameter int unsigned      N      = 16,
    parameter int unsigned      NUM_PE = 4,
    parameter int unsigned      WIDTH  = 16,
    parameter int unsigned      ITERS  = 8,
    parameter logic [WIDTH-1:0] D      = 16'h2666,
    localparam int unsigned     M      = N * NUM_PE,
    localparam int unsigned     PW     = (M > 1) ? $clog2(M) : 1,
    // Kept at least one bit so a single-PE system still has an id port.
    localparam int unsigned     IW     = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
    localparam int unsigned     ITW    = $clog2(ITERS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [IW-1:0]        id,
    input  logic [N*M-1:0]       adjacency,
    input  logic [N*WIDTH-1:0]   weights,
    pagerank_pe_if.master        noc,
    output logic [ITW-1:0]       iter,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [N*WIDTH-1:0]   vals
);
    localparam int unsigned      NW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned      AW   = WIDTH + PW;
    localparam int unsigned      SW   = 2 * WIDTH + PW + 1;
    localparam longint unsigned  ONE  = 64'd1 << WIDTH;
    localparam logic [WIDTH-1:0] INIT = WIDTH'(ONE / M);
    localparam logic [WIDTH:0]   OMD  = (WIDTH + 1)'(ONE - D);
    localparam logic [WIDTH-1:0] DM   = WIDTH'(D / M);
    localparam logic [PW-1:0]    LAST = PW'(M - 1);

    typedef enum logic [2:0] {IDLE, SCAN, REQ, WAIT, WRITE, BARRIER, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] cur [N];
    logic [WIDTH-1:0] nxt [N];
    logic [WIDTH-1:0] wts [N];
    logic [M-1:0]     adj [N];
    logic [AW-1:0]    acc;
    logic [NW-1:0]    p;
    logic [PW-1:0]    r;

    logic [PW:0]      base;
    logic             r_local, q_local;
    logic [NW-1:0]    r_idx, q_idx;
    logic [WIDTH-1:0] r_contrib, q_contrib;
    logic [SW-1:0]    scaled, sum;
    logic [WIDTH-1:0] new_val;

    function automatic logic [WIDTH-1:0] contrib(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] w);
        logic [2*WIDTH-1:0] prod;
        prod = v * w;
        return WIDTH'(prod >> WIDTH);
    endfunction

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            wts[i]                   = weights[i*WIDTH +: WIDTH];
            adj[i]                   = adjacency[i*M +: M];
            vals[i*WIDTH +: WIDTH]   = cur[i];
        end
    end

    // Range checks use one extra bit so base+N == M does not wrap.
    always_comb begin
        base      = (PW + 1)'(id) * (PW + 1)'(N);
        r_local   = ({1'b0, r} >= base) && ({1'b0, r} < base + (PW + 1)'(N));
        q_local   = ({1'b0, noc.qry_page} >= base) &&
                    ({1'b0, noc.qry_page} < base + (PW + 1)'(N));
        r_idx     = NW'(r - base[PW-1:0]);
        q_idx     = NW'(noc.qry_page - base[PW-1:0]);
        r_contrib = contrib(cur[r_idx], wts[r_idx]);
        q_contrib = contrib(cur[q_idx], wts[q_idx]);
        scaled    = SW'(OMD) * SW'(acc);
        sum       = (scaled >> WIDTH) + SW'(DM);
        new_val   = (sum > SW'(ONE - 1)) ? '1 : sum[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            for (int unsigned i = 0; i < N; i++) begin
                cur[i] <= INIT;
                nxt[i] <= '0;
            end
            acc           <= '0;
            p             <= '0;
            r             <= '0;
            iter          <= '0;
            noc.req_valid <= 1'b0;
            noc.req_page  <= '0;
            noc.rep_valid <= 1'b0;
            noc.rep_data  <= '0;
            noc.sync_done <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            // Query service reads cur before any swap on this edge takes effect.
            noc.rep_valid <= noc.qry_valid;
            noc.rep_data  <= (noc.qry_valid && q_local) ? q_contrib : '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SCAN;
                        p     <= '0;
                        r     <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SCAN: begin
                    if (adj[p][r] && !r_local) begin
                        state         <= REQ;
                        noc.req_valid <= 1'b1;
                        noc.req_page  <= r;
                    end else begin
                        if (adj[p][r])
                            acc <= acc + AW'(r_contrib);
                        if (r == LAST)
                            state <= WRITE;
                        else
                            r <= r + 1'b1;
                    end
                end
                REQ: begin
                    if (noc.req_ready) begin
                        noc.req_valid <= 1'b0;
                        state         <= WAIT;
                    end
                end
                WAIT: begin
                    if (noc.rsp_valid) begin
                        if (noc.rsp_data[PW-1:0] == r) begin
                            acc <= acc + AW'(noc.rsp_data[AW-1:PW]);
                            if (r == LAST) begin
                                state <= WRITE;
                            end else begin
                                r     <= r + 1'b1;
                                state <= SCAN;
                            end
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    nxt[p] <= new_val;
                    acc    <= '0;
                    if (p == NW'(N - 1)) begin
                        state         <= BARRIER;
                        noc.sync_done <= 1'b1;
                    end else begin
                        p     <= p + 1'b1;
                        r     <= '0;
                        state <= SCAN;
                    end
                end
                BARRIER: begin
                    if (noc.sync_go) begin
                        for (int unsigned i = 0; i < N; i++)
                            cur[i] <= nxt[i];
                        iter          <= iter + 1'b1;
                        noc.sync_done <= 1'b0;
                        if (iter == ITW'(ITERS - 1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= SCAN;
                            p     <= '0;
                            r     <= '0;
                        end
                    end
                end
                DONE: begin
                    if (start) begin
                        done  <= 1'b0;
                        iter  <= '0;
                        state <= SCAN;
                        p     <= '0;
                        r     <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pagerank_pe.sv
// Bench for pagerank_pe: a default 4-PE instance for the NoC paths and a small
// single-PE instance checked against an arithmetic PageRank model.
module tb_pagerank_pe;
    localparam int unsigned N = 16, NUM_PE = 4, WIDTH = 16, M = 64, PW = 6, IW = 2, ITW = 4;
    localparam int unsigned SN = 4, SM = 4, SPW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic                 start, start_s;
    logic [IW-1:0]        id;
    logic                 id_s;
    logic [N*M-1:0]       adjacency;
    logic [SN*SM-1:0]     adjacency_s;
    logic [N*WIDTH-1:0]   weights;
    logic [SN*WIDTH-1:0]  weights_s;
    logic [ITW-1:0]       iter;
    logic                 iter_s;
    logic                 busy, done, err, busy_s, done_s, err_s;
    logic [N*WIDTH-1:0]   vals;
    logic [SN*WIDTH-1:0]  vals_s;

    pagerank_pe_if #(.WIDTH(WIDTH), .PW(PW))  bus ();
    pagerank_pe_if #(.WIDTH(WIDTH), .PW(SPW)) bus_s ();

    pagerank_pe #(.N(N), .NUM_PE(NUM_PE), .WIDTH(WIDTH), .ITERS(8), .D(16'h2666)) dut (
        .clk(clk), .reset(reset), .start(start), .id(id), .adjacency(adjacency),
        .weights(weights), .noc(bus), .iter(iter), .busy(busy), .done(done),
        .err(err), .vals(vals)
    );

    pagerank_pe #(.N(SN), .NUM_PE(1), .WIDTH(WIDTH), .ITERS(1), .D(16'h2666)) dut_s (
        .clk(clk), .reset(reset), .start(start_s), .id(id_s), .adjacency(adjacency_s),
        .weights(weights_s), .noc(bus_s), .iter(iter_s), .busy(busy_s), .done(done_s),
        .err(err_s), .vals(vals_s)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arithmetic: contribution = value/outdeg, new = d/M + (1-d)*sum, saturated.
    function automatic logic [15:0] contrib_m(input longint unsigned v, input longint unsigned w);
        return 16'((v * w) / 65536);
    endfunction

    function automatic logic [15:0] update_m(input longint unsigned acc, input longint unsigned m);
        longint unsigned x;
        x = 64'h2666 / m + ((65536 - 64'h2666) * acc) / 65536;
        return (x > 65535) ? 16'hFFFF : 16'(x);
    endfunction

    longint unsigned mcur [SN];
    longint unsigned mnxt [SN];
    logic [255:0]    exp_v;
    logic [15:0]     exp_rep;
    longint unsigned acc_m;
    int unsigned     qp;

    task automatic model_small_iter();
        for (int pp = 0; pp < SN; pp++) begin
            acc_m = 0;
            for (int rr = 0; rr < SM; rr++)
                if (adjacency_s[pp*SM + rr])
                    acc_m += contrib_m(mcur[rr], weights_s[rr*16 +: 16]);
            mnxt[pp] = update_m(acc_m, SM);
        end
        exp_v = '0;
        for (int pp = 0; pp < SN; pp++) begin
            mcur[pp] = mnxt[pp];
            exp_v[pp*16 +: 16] = 16'(mcur[pp]);
        end
    endtask

    task automatic run_small(input string tag);
        model_small_iter();
        start_s = 1'b1;
        tick();
        start_s = 1'b0;
        check({tag, "_busy"}, 256'(busy_s), 256'(1));
        for (int n = 0; n < 200 && done_s !== 1'b1; n++) tick();
        check({tag, "_done"}, 256'(done_s), 256'(1));
        check({tag, "_vals"}, 256'(vals_s), exp_v);
        check({tag, "_iter"}, 256'(iter_s), 256'(1));
    endtask

    function automatic logic [255:0] fill16(input logic [15:0] v);
        logic [255:0] t;
        for (int i = 0; i < N; i++) t[i*16 +: 16] = v;
        return t;
    endfunction

    initial begin
        reset = 1'b0; start = 1'b0; start_s = 1'b0; id = '0; id_s = 1'b0;
        adjacency = '0; adjacency_s = '0; weights = '0; weights_s = '0;
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0;
        bus.qry_valid = 1'b0; bus.qry_page = '0; bus.sync_go = 1'b0;
        bus_s.req_ready = 1'b1; bus_s.rsp_valid = 1'b0; bus_s.rsp_data = '0;
        bus_s.qry_valid = 1'b0; bus_s.qry_page = '0; bus_s.sync_go = 1'b1;
        tick(); tick();

        // Reset state
        check("rst_vals", 256'(vals), fill16(16'h0400));
        check("rst_vals_s", 256'(vals_s), 256'({4{16'h4000}}));
        check("rst_flags", 256'({busy, done, err, bus.req_valid, bus.rep_valid, bus.sync_done}), 256'(0));
        check("rst_iter", 256'(iter), 256'(0));
        reset = 1'b1;
        tick();

        // Single-PE, no links: one iteration gives d/M everywhere
        for (int i = 0; i < SN; i++) mcur[i] = 64'h4000;
        for (int i = 0; i < SN; i++) weights_s[i*16 +: 16] = 16'($urandom);
        run_small("noadj");
        check("noadj_const", 256'(vals_s), 256'({4{16'h0999}}));
        check("noadj_busy_off", 256'(busy_s), 256'(0));

        // Random graphs, each start continues from the current values
        for (int k = 0; k < 4; k++) begin
            adjacency_s = 16'($urandom);
            for (int i = 0; i < SN; i++) weights_s[i*16 +: 16] = 16'($urandom);
            start_s = 1'b1;
            tick();
            check("restart_clears_done", 256'({done_s, iter_s}), 256'(0));
            start_s = 1'b0;
            model_small_iter();
            for (int n = 0; n < 200 && done_s !== 1'b1; n++) tick();
            check("rand_done", 256'(done_s), 256'(1));
            check("rand_vals", 256'(vals_s), exp_v);
        end

        // Fully connected with maximal weights drives values into saturation
        adjacency_s = '1;
        weights_s   = '1;
        for (int k = 0; k < 5; k++) run_small("sat");
        check("sat_ceiling", 256'(vals_s), 256'({4{16'hFFFF}}));

        // Query service on the 4-PE instance, id=1 owns pages 16..31
        id = 2'd1;
        for (int i = 0; i < N; i++) weights[i*16 +: 16] = 16'($urandom);
        weights[2*16 +: 16] = 16'h8000;
        bus.qry_valid = 1'b1;
        bus.qry_page  = 6'd18;
        tick();
        check("qry18_valid", 256'(bus.rep_valid), 256'(1));
        check("qry18_data", 256'(bus.rep_data), 256'(16'h0200));
        bus.qry_page = 6'd5;
        tick();
        check("qry5_valid", 256'(bus.rep_valid), 256'(1));
        check("qry5_data", 256'(bus.rep_data), 256'(0));
        for (int k = 0; k < 24; k++) begin
            qp = $urandom_range(63);
            bus.qry_page = 6'(qp);
            exp_rep = (qp >= 16 && qp < 32) ? contrib_m(64'h400, weights[(qp-16)*16 +: 16]) : 16'h0;
            tick();
            check("qry_rand", 256'({bus.rep_valid, bus.rep_data}), 256'({1'b1, exp_rep}));
        end
        bus.qry_valid = 1'b0;
        tick();
        check("qry_idle", 256'(bus.rep_valid), 256'(0));

        // Remote fetch of page 20 for local page 0
        id = 2'd0;
        adjacency = '0;
        adjacency[20] = 1'b1;
        weights[15:0] = 16'hFFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 100 && bus.req_valid !== 1'b1; n++) tick();
        check("req_seen", 256'(bus.req_valid), 256'(1));
        check("req_page", 256'(bus.req_page), 256'(20));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("req_hold", 256'({bus.req_valid, bus.req_page}), 256'({1'b1, 6'd20}));
        end
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        check("req_accepted", 256'(bus.req_valid), 256'(0));

        bus.rsp_valid = 1'b1;
        bus.rsp_data  = {16'h1234, 6'd21};
        tick();
        bus.rsp_valid = 1'b0;
        check("err_set", 256'(err), 256'(1));
        tick(); tick(); tick();
        check("wait_holds", 256'({err, busy, bus.req_valid, bus.sync_done}), 256'(4'b1100));
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = {16'h0200, 6'd20};
        tick();
        bus.rsp_valid = 1'b0;

        for (int n = 0; n < 3000 && bus.sync_done !== 1'b1; n++) tick();
        check("sync_done_seen", 256'(bus.sync_done), 256'(1));
        for (int k = 0; k < 5; k++) begin
            check("barrier_vals", 256'(vals), fill16(16'h0400));
            check("barrier_sync", 256'(bus.sync_done), 256'(1));
            tick();
        end

        // Swap together with a query to page 0: reply comes from pre-swap value
        bus.sync_go   = 1'b1;
        bus.qry_valid = 1'b1;
        bus.qry_page  = 6'd0;
        tick();
        bus.sync_go = 1'b0;
        check("swap_reply", 256'(bus.rep_data), 256'(contrib_m(64'h400, 64'hFFFF)));
        exp_v = fill16(update_m(0, M));
        exp_v[15:0] = update_m(64'h200, M);
        check("swap_vals", 256'(vals), exp_v);
        check("swap_page0", 256'(vals[15:0]), 256'(16'h024C));
        check("swap_iter", 256'(iter), 256'(1));
        check("swap_sync_off", 256'(bus.sync_done), 256'(0));
        tick();
        check("post_reply", 256'(bus.rep_data), 256'(contrib_m(64'h24C, 64'hFFFF)));
        bus.qry_valid = 1'b0;

        // Second iteration: reset while waiting for the response
        for (int n = 0; n < 200 && bus.req_valid !== 1'b1; n++) tick();
        check("req2_seen", 256'(bus.req_valid), 256'(1));
        bus.req_ready = 1'b1;
        tick();
        bus.req_ready = 1'b0;
        check("err_sticky", 256'(err), 256'(1));
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("mid_rst_vals", 256'(vals), fill16(16'h0400));
        check("mid_rst_flags", 256'({bus.req_valid, busy, err, bus.sync_done, done}), 256'(0));
        check("mid_rst_iter", 256'(iter), 256'(0));
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = {16'h1234, 6'd21};
        tick();
        bus.rsp_valid = 1'b0;
        tick();
        check("idle_rsp_ignored", 256'({err, busy}), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
